// File: rtl/stream_reader_pkg.sv
// Shared types and constants for the Wishbone SRAM stream reader.
package stream_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitSpace,
        StDrain
    } state_e;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/wb_sram_stream_reader_if.sv
// Wishbone classic read-master bundle between the stream reader and the SRAM slave.
interface wb_sram_stream_reader_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_we_o,
        output wbm_sel_o,
        output wbm_adr_o,
        input  wbm_dat_i,
        input  wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_we_o,
        input  wbm_sel_o,
        input  wbm_adr_o,
        output wbm_dat_i,
        output wbm_ack_i
    );

endinterface

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with single-cycle flush.
module stream_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FullLevel);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/wb_sram_stream_reader.sv
// Wishbone read master streaming a block of SRAM words through a FIFO.
// Optional `STREAM_READER_WRAP_EN: circular re-read of the block until aborted.
module wb_sram_stream_reader
    import stream_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        start_i,
    input  logic [31:0]                 base_addr_i,
    input  logic [LEN_WIDTH-1:0]        len_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic                        done_o,
    wb_sram_stream_reader_if.master     wbm,
    output logic [31:0]                 m_data_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

    localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 stb_q, stb_d;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 unused_addr_bits;

`ifdef STREAM_READER_WRAP_EN
    logic [31:0]          base_q, base_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
`endif

    assign unused_addr_bits = ^base_addr_i[1:0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stb_d       = stb_q;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
`ifdef STREAM_READER_WRAP_EN
        base_d      = base_q;
        len_d       = len_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d      = {base_addr_i[31:2], 2'b00};
                    remaining_d = len_i;
`ifdef STREAM_READER_WRAP_EN
                    base_d      = {base_addr_i[31:2], 2'b00};
                    len_d       = len_i;
`endif
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        if (!fifo_full) begin
                            state_d = StIssue;
                            stb_d   = 1'b1;
                        end else begin
                            state_d = StWaitSpace;
                        end
                    end
                end
            end
            StIssue: begin
                if (abort_i) begin
                    if (wbm.wbm_ack_i) begin
                        stb_d      = 1'b0;
                        busy_d     = 1'b0;
                        fifo_flush = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (wbm.wbm_ack_i) begin
                    // Strobe must drop here: the slave re-acks a held strobe.
                    fifo_push   = 1'b1;
                    stb_d       = 1'b0;
                    addr_d      = addr_q + WORD_BYTES;
                    remaining_d = remaining_q - LenOne;
                    if (remaining_q == LenOne) begin
                        done_d = 1'b1;
`ifdef STREAM_READER_WRAP_EN
                        addr_d      = base_q;
                        remaining_d = len_q;
                        state_d     = StWaitSpace;
`else
                        busy_d  = 1'b0;
                        state_d = StIdle;
`endif
                    end else begin
                        state_d = StWaitSpace;
                    end
                end
            end
            StWaitSpace: begin
                if (abort_i) begin
                    busy_d     = 1'b0;
                    fifo_flush = 1'b1;
                    state_d    = StIdle;
                end else if (!fifo_full) begin
                    stb_d   = 1'b1;
                    state_d = StIssue;
                end
            end
            StDrain: begin
                if (wbm.wbm_ack_i) begin
                    stb_d      = 1'b0;
                    busy_d     = 1'b0;
                    fifo_flush = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stb_q       <= stb_d;
        end
    end

`ifdef STREAM_READER_WRAP_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            base_q <= '0;
            len_q  <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
        end
    end
`endif

    assign fifo_pop = m_valid_o && m_ready_i;

    stream_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (wbm.wbm_dat_i),
        .rdata (m_data_o),
        .level (fifo_level_o),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m_valid_o     = !fifo_empty;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign wbm.wbm_cyc_o = stb_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_sel_o = WB_SEL_ALL;
    assign wbm.wbm_adr_o = addr_q;

endmodule

// File: doc/wb_sram_stream_reader.md
Name: wb_sram_stream_reader

Overview:
Wishbone classic master sitting directly upstream of the SRAM Wishbone slave. It reads a block of consecutive 32-bit words from SRAM and delivers them through an internal FIFO to a valid/ready stream consumer, such as a display or serializer.
It is started by a command pulse carrying a byte base address and a word count. It raises a one-cycle done pulse when the last word has been pushed into the FIFO.

Parameters:
FIFO_DEPTH, 8, number of 32-bit entries in the output FIFO; power of 2, minimum 2
LEN_WIDTH, 16, width of the word-count command field

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  reset
start_i  input  1  command strobe; sampled only in IDLE
base_addr_i  input  32  byte start address; bits [1:0] ignored and treated as 0
len_i  input  LEN_WIDTH  number of words to read
abort_i  input  1  cancel the current job
busy_o  output  1  high from the accepted start until return to IDLE
done_o  output  1  one-cycle pulse at job completion
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  held constant 0
wbm_sel_o  output  4  held constant 4'hF
wbm_adr_o  output  32  byte address, word aligned
wbm_dat_i  input  32  read data
wbm_ack_i  input  1  acknowledge
m_data_o  output  32  stream data, taken from FIFO head
m_valid_o  output  1  FIFO not empty
m_ready_i  input  1  consumer accepts data
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is wb_rst_i, asynchronous, active-high. Clock is wb_clk_i.
- All registered outputs reset to 0: busy_o, done_o, wbm_cyc_o, wbm_stb_o, wbm_adr_o, m_valid_o, fifo_level_o. The FIFO is emptied.
- Reset mid-job drops cyc/stb immediately; no further ack is expected or consumed.
- States:
  - IDLE
  - ISSUE: cyc=stb=1, held until ack
  - WAIT_SPACE: FIFO full, bus idle
  - DRAIN: abort, waiting for ack
- IDLE with start_i=1:
  - Latch addr = {base_addr_i[31:2], 2'b00} and remaining = len_i; set busy_o.
  - If len_i=0: done_o pulses on the next cycle, no bus activity, return to IDLE.
  - Otherwise go to ISSUE if the FIFO is not full, else WAIT_SPACE.
- start_i outside IDLE is ignored.
- cyc and stb are always equal and registered. wbm_adr_o is stable while stb=1.
- ISSUE, cycle with wbm_ack_i=1:
  - Push wbm_dat_i into the FIFO.
  - Deassert stb/cyc at that edge. This is mandatory: the slave re-acks a held strobe.
  - addr += 4, wrapping modulo 2^32; remaining -= 1.
  - If remaining reaches 0: done_o pulses the next cycle, busy_o falls, go to IDLE.
  - Else go to ISSUE the next cycle if the FIFO is not full, else WAIT_SPACE.
- Peak throughput against the SRAM slave is 1 word per 2 cycles: stb high, ack, stb low, stb high.
- At most one transaction is outstanding. Issue only when level < FIFO_DEPTH, so the push on ack never overflows.
- WAIT_SPACE goes to ISSUE in the cycle after level < FIFO_DEPTH.
- FIFO push and pop in the same cycle are both performed; level is unchanged.
- Pop occurs when m_valid_o && m_ready_i.
- m_data_o is valid whenever m_valid_o=1 and is stable until popped.
- abort_i:
  - IDLE: no effect.
  - WAIT_SPACE: go to IDLE next cycle.
  - ISSUE without ack: go to DRAIN; stb held until ack; data discarded.
  - ISSUE with ack in the same cycle: word discarded, go to IDLE.
  - In all cases the FIFO is flushed on entering IDLE, busy_o falls, and done_o is not pulsed.
- If abort_i and the final ack coincide, abort wins: no done, FIFO flushed.
- remaining is LEN_WIDTH bits, so the maximum job length is 2^LEN_WIDTH−1 words.

Optional Feature:
STREAM_READER_WRAP_EN
- Defined: circular mode for display refresh. When remaining reaches 0, addr reloads the latched base and remaining reloads the latched length. done_o pulses once per completed pass but busy_o stays high. The job ends only via abort_i.
- Undefined: single-pass behaviour exactly as described above.

Decomposition:
- Package stream_reader_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_SPACE, DRAIN)
  - WB_SEL_ALL = 4'hF
  - WORD_BYTES = 4
- One sub-module, stream_fifo:
  - synchronous, parameterised width and depth
  - push, pop, flush, level, empty, full
  - first-word-fall-through head output
- The FSM, address counter and length counter stay in the top module.

Test Plan:
- Against the SRAM slave model preloaded with mem[0x10..0x13] = 0xA0..0xA3, with m_ready_i=1: start base=0x40, len=4 → four reads at addresses 0x40, 0x44, 0x48, 0x4C. Stream outputs A0..A3 in order; done_o pulses once; stb never high in the cycle after an ack.
- FIFO_DEPTH=8, m_ready_i=0: start base 0, len=12 → exactly 8 reads, then WAIT_SPACE. Raise ready → remaining 4 reads occur; 12 words delivered in order.
- start with len=0 → done_o pulses one cycle later; wbm_cyc_o stays 0.
- Abort mid-ISSUE with ack delayed 3 cycles → stb held until ack; FIFO level becomes 0; no done_o; the next start works normally.
- Assert wb_rst_i while stb=1 with 3 words queued → all outputs 0 immediately, level 0.
- With the wrap macro defined, base=0x100, len=2, run 3 passes → address sequence 0x100, 0x104, 0x100, 0x104, 0x100, 0x104; done_o pulses 3 times; busy_o stays high until abort.
